// File: rtl/enokida_param_cache.sv
// Set-associative write-through, no-write-allocate data cache with configurable geometry,
// uncached bypass, whole-cache flush and saturating statistics. One outstanding transaction.
module enokida_param_cache #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAYS        = 2,
  parameter int unsigned SETS        = 64,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     proc_cache_data_req_i,
  input  logic [ADDR_WIDTH-1:0]    proc_cache_data_addr_i,
  input  logic                     proc_cache_data_we_i,
  input  logic [DATA_WIDTH/8-1:0]  proc_cache_data_be_i,
  input  logic [DATA_WIDTH-1:0]    proc_cache_data_wdata_i,
  output logic                     proc_cache_data_gnt_o,
  output logic                     proc_cache_data_rvalid_o,
  output logic [DATA_WIDTH-1:0]    proc_cache_data_rdata_o,
  input  logic                     cache_mem_data_gnt_i,
  input  logic                     cache_mem_data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]    cache_mem_data_rdata_i,
  output logic                     cache_mem_data_req_o,
  output logic [ADDR_WIDTH-1:0]    cache_mem_data_addr_o,
  output logic                     cache_mem_data_we_o,
  output logic [DATA_WIDTH/8-1:0]  cache_mem_data_be_o,
  output logic [DATA_WIDTH-1:0]    cache_mem_data_wdata_o,
  input  logic                     bypass_i,
  input  logic                     flush_i,
  output logic                     busy_o,
  output logic [COUNT_WIDTH-1:0]   trans_count,
  output logic [COUNT_WIDTH-1:0]   hit_count,
  output logic [COUNT_WIDTH-1:0]   miss_count
);

  localparam int unsigned BeW  = DATA_WIDTH / 8;
  localparam int unsigned Off  = (BeW > 1) ? $clog2(BeW) : 0;
  localparam int unsigned IdxW = $clog2(SETS);
  localparam int unsigned TagW = ADDR_WIDTH - Off - IdxW;
  localparam int unsigned WayW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {StIdle, StLookup, StMemReq, StMemWait, StResp, StFlush} state_e;

  state_e                  state_q, state_d;
  logic                    flush_pend_q, flush_pend_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    we_q;
  logic [BeW-1:0]          be_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    bypass_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [COUNT_WIDTH-1:0]  trans_q, hit_q, miss_q;

  logic [WAYS-1:0]         valid_q [SETS];
  logic [WayW-1:0]         rr_q    [SETS];
  logic [TagW-1:0]         tag_q   [SETS][WAYS];
  logic [DATA_WIDTH-1:0]   data_q  [SETS][WAYS];

  logic [IdxW-1:0]         idx;
  logic [TagW-1:0]         tag;
  logic                    hit;
  logic [WayW-1:0]         hit_way;
  logic [WayW-1:0]         victim;
  logic                    victim_repl;
  logic [DATA_WIDTH-1:0]   merged;
  logic                    gnt;
  logic                    lookup;
  logic                    fill_en;
  logic                    wr_hit_en;

  assign idx = addr_q[Off +: IdxW];
  assign tag = addr_q[ADDR_WIDTH-1 -: TagW];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WayW'(w);
      end
    end
  end

  // Lowest invalid way wins; only when the set is full does the round-robin pointer decide.
  always_comb begin
    victim      = rr_q[idx];
    victim_repl = 1'b1;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        victim      = WayW'(w);
        victim_repl = 1'b0;
      end
    end
  end

  always_comb begin
    merged = data_q[idx][hit_way];
    for (int b = 0; b < int'(BeW); b++) begin
      if (be_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  assign gnt       = proc_cache_data_req_i && (state_q == StIdle) && !flush_pend_q && !flush_i;
  assign lookup    = (state_q == StLookup) && !bypass_q;
  assign fill_en   = (state_q == StMemWait) && cache_mem_data_rvalid_i && !we_q && !bypass_q;
  assign wr_hit_en = lookup && hit && we_q;

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    unique case (state_q)
      StIdle: begin
        if (flush_i || flush_pend_q) state_d = StFlush;
        else if (proc_cache_data_req_i) state_d = StLookup;
      end
      StLookup: begin
        if (!bypass_q && hit && !we_q) state_d = StResp;
        else state_d = StMemReq;
      end
      StMemReq:  if (cache_mem_data_gnt_i) state_d = StMemWait;
      StMemWait: if (cache_mem_data_rvalid_i) state_d = StResp;
      StResp:    state_d = StIdle;
      StFlush: begin
        state_d      = StIdle;
        flush_pend_d = 1'b0;
      end
      default:   state_d = StIdle;
    endcase
    if (flush_i && (state_q != StIdle) && (state_q != StFlush)) flush_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      flush_pend_q <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      bypass_q     <= 1'b0;
      rdata_q      <= '0;
      trans_q      <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      if (gnt) begin
        addr_q   <= proc_cache_data_addr_i;
        we_q     <= proc_cache_data_we_i;
        be_q     <= proc_cache_data_be_i;
        wdata_q  <= proc_cache_data_wdata_i;
        bypass_q <= bypass_i;
        if (trans_q != '1) trans_q <= trans_q + COUNT_WIDTH'(1);
      end
      if (lookup && hit && (hit_q != '1)) hit_q <= hit_q + COUNT_WIDTH'(1);
      if (lookup && !hit && (miss_q != '1)) miss_q <= miss_q + COUNT_WIDTH'(1);
      if (lookup && hit && !we_q) rdata_q <= data_q[idx][hit_way];
      if ((state_q == StMemWait) && cache_mem_data_rvalid_i && !we_q) begin
        rdata_q <= cache_mem_data_rdata_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (state_q == StFlush) begin
      for (int s = 0; s < int'(SETS); s++) valid_q[s] <= '0;
    end else if (fill_en) begin
      valid_q[idx][victim] <= 1'b1;
      if (victim_repl) begin
        rr_q[idx] <= (int'(victim) == int'(WAYS) - 1) ? '0 : victim + WayW'(1);
      end
    end
  end

  // Tag/data contents are qualified by valid bits, so they need no reset.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx][victim]  <= tag;
      data_q[idx][victim] <= cache_mem_data_rdata_i;
    end else if (wr_hit_en) begin
      data_q[idx][hit_way] <= merged;
    end
  end

  always_comb begin
    cache_mem_data_req_o   = (state_q == StMemReq);
    cache_mem_data_addr_o  = '0;
    cache_mem_data_we_o    = 1'b0;
    cache_mem_data_be_o    = '0;
    cache_mem_data_wdata_o = '0;
    if (cache_mem_data_req_o) begin
      cache_mem_data_addr_o = addr_q & ~ADDR_WIDTH'(BeW - 1);
      cache_mem_data_we_o   = we_q;
      cache_mem_data_be_o   = we_q ? be_q : '1;
      if (we_q) cache_mem_data_wdata_o = wdata_q;
    end
  end

  assign proc_cache_data_gnt_o    = gnt;
  assign proc_cache_data_rvalid_o = (state_q == StResp);
  assign proc_cache_data_rdata_o  = rdata_q;
  assign busy_o                   = (state_q != StIdle) || flush_pend_q;
  assign trans_count              = trans_q;
  assign hit_count                = hit_q;
  assign miss_count               = miss_q;

endmodule

// File: tb/tb_enokida_param_cache.sv
// Directed bench for enokida_param_cache: a default-geometry instance plus a 4-bit-counter
// instance sharing the same stimulus to observe counter saturation.
module tb_enokida_param_cache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, bypass = 1'b0, flush = 1'b0;
  logic [15:0] addr = '0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        gnt, rvalid, mem_req, mem_we, busy;
  logic [31:0] rdata, mem_wdata;
  logic [15:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] trans, hits, misses;

  logic        s_gnt, s_rvalid, s_mem_req, s_mem_we, s_busy;
  logic [31:0] s_rdata, s_mem_wdata;
  logic [15:0] s_mem_addr;
  logic [3:0]  s_mem_be;
  logic [3:0]  s_trans, s_hits, s_misses;

  int n_pass = 0;
  int n_checks = 0;
  int n_trans = 0;

  logic [31:0] r_data;
  bit          r_memreq;
  logic [15:0] r_maddr;
  logic        r_mwe;
  logic [3:0]  r_mbe;
  logic [31:0] r_mwdata;
  int          r_lat;

  always #5 clk = ~clk;

  enokida_param_cache dut (
    .clk(clk), .rst_n(rst_n),
    .proc_cache_data_req_i(req), .proc_cache_data_addr_i(addr), .proc_cache_data_we_i(we),
    .proc_cache_data_be_i(be), .proc_cache_data_wdata_i(wdata),
    .proc_cache_data_gnt_o(gnt), .proc_cache_data_rvalid_o(rvalid),
    .proc_cache_data_rdata_o(rdata),
    .cache_mem_data_gnt_i(mem_gnt), .cache_mem_data_rvalid_i(mem_rvalid),
    .cache_mem_data_rdata_i(mem_rdata),
    .cache_mem_data_req_o(mem_req), .cache_mem_data_addr_o(mem_addr),
    .cache_mem_data_we_o(mem_we), .cache_mem_data_be_o(mem_be),
    .cache_mem_data_wdata_o(mem_wdata),
    .bypass_i(bypass), .flush_i(flush), .busy_o(busy),
    .trans_count(trans), .hit_count(hits), .miss_count(misses)
  );

  enokida_param_cache #(.COUNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .proc_cache_data_req_i(req), .proc_cache_data_addr_i(addr), .proc_cache_data_we_i(we),
    .proc_cache_data_be_i(be), .proc_cache_data_wdata_i(wdata),
    .proc_cache_data_gnt_o(s_gnt), .proc_cache_data_rvalid_o(s_rvalid),
    .proc_cache_data_rdata_o(s_rdata),
    .cache_mem_data_gnt_i(mem_gnt), .cache_mem_data_rvalid_i(mem_rvalid),
    .cache_mem_data_rdata_i(mem_rdata),
    .cache_mem_data_req_o(s_mem_req), .cache_mem_data_addr_o(s_mem_addr),
    .cache_mem_data_we_o(s_mem_we), .cache_mem_data_be_o(s_mem_be),
    .cache_mem_data_wdata_o(s_mem_wdata),
    .bypass_i(bypass), .flush_i(flush), .busy_o(s_busy),
    .trans_count(s_trans), .hit_count(s_hits), .miss_count(s_misses)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One processor access; services at most one memory handshake, optionally pulsing flush
  // while the memory response is outstanding.
  task automatic access(input logic [15:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] wd, input logic byp, input logic [31:0] md,
                        input bit flush_mid);
    int  n;
    bit  done;
    @(negedge clk);
    req = 1'b1; addr = a; we = w; be = b; wdata = wd; bypass = byp;
    #1;
    n = 0;
    while (!gnt && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("grant", {63'd0, gnt}, 64'd1);
    @(posedge clk); #1;
    req = 1'b0; bypass = 1'b0; we = 1'b0;
    n_trans++;
    r_memreq = 1'b0; r_lat = 0; done = 1'b0;
    while (!done && r_lat < 30) begin
      @(negedge clk);
      r_lat++;
      if (rvalid) begin
        r_data = rdata;
        done   = 1'b1;
      end else if (mem_req) begin
        r_memreq = 1'b1; r_maddr = mem_addr; r_mwe = mem_we; r_mbe = mem_be;
        r_mwdata = mem_wdata;
        mem_gnt = 1'b1;
        @(posedge clk); #1 mem_gnt = 1'b0;
        if (flush_mid) begin
          flush = 1'b1;
          @(posedge clk); #1 flush = 1'b0;
        end
        mem_rvalid = 1'b1; mem_rdata = md;
        @(posedge clk); #1 mem_rvalid = 1'b0;
      end
    end
    check("response", {63'd0, done}, 64'd1);
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] md);
    access(a, 1'b0, 4'hF, 32'h0, 1'b0, md, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_rvalid", {63'd0, rvalid}, 64'd0);
    check("rst_mem_req", {63'd0, mem_req}, 64'd0);
    check("rst_mem_be", {60'd0, mem_be}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_trans", {32'd0, trans}, 64'd0);
    check("rst_hits", {32'd0, hits}, 64'd0);
    check("rst_misses", {32'd0, misses}, 64'd0);
    check("rst_rdata", {32'd0, rdata}, 64'd0);
    rst_n = 1'b1;

    // Cold read miss then hit
    rd(16'h0040, 32'hDEADBEEF);
    check("cold_memreq", {63'd0, r_memreq}, 64'd1);
    check("cold_maddr", {48'd0, r_maddr}, 64'h0040);
    check("cold_mwe", {63'd0, r_mwe}, 64'd0);
    check("cold_mbe", {60'd0, r_mbe}, 64'hF);
    check("cold_data", {32'd0, r_data}, 64'hDEADBEEF);
    check("cold_misses", {32'd0, misses}, 64'd1);
    check("cold_trans", {32'd0, trans}, 64'd1);
    rd(16'h0040, 32'h0);
    check("hit_memreq", {63'd0, r_memreq}, 64'd0);
    check("hit_lat", 64'(r_lat), 64'd2);
    check("hit_data", {32'd0, r_data}, 64'hDEADBEEF);
    check("hit_hits", {32'd0, hits}, 64'd1);

    // Set 0 with tags 1,2,3: C evicts A (way0); A then evicts B (way1)
    rd(16'h0100, 32'hA0A0A0A0);
    rd(16'h0200, 32'hB0B0B0B0);
    rd(16'h0300, 32'hC0C0C0C0);
    check("c_memreq", {63'd0, r_memreq}, 64'd1);
    check("abc_misses", {32'd0, misses}, 64'd4);
    rd(16'h0200, 32'h0);
    check("b_hit_memreq", {63'd0, r_memreq}, 64'd0);
    check("b_hit_data", {32'd0, r_data}, 64'hB0B0B0B0);
    rd(16'h0100, 32'hA1A1A1A1);
    check("a_miss_memreq", {63'd0, r_memreq}, 64'd1);
    check("a_miss_data", {32'd0, r_data}, 64'hA1A1A1A1);
    rd(16'h0300, 32'h0);
    check("c_kept_memreq", {63'd0, r_memreq}, 64'd0);
    check("c_kept_data", {32'd0, r_data}, 64'hC0C0C0C0);
    rd(16'h0200, 32'hB1B1B1B1);
    check("b_evicted_memreq", {63'd0, r_memreq}, 64'd1);
    check("set0_hits", {32'd0, hits}, 64'd3);
    check("set0_misses", {32'd0, misses}, 64'd6);

    // Partial write hit, write-through
    access(16'h0040, 1'b1, 4'b0011, 32'h00001234, 1'b0, 32'h0, 1'b0);
    check("wr_memreq", {63'd0, r_memreq}, 64'd1);
    check("wr_mwe", {63'd0, r_mwe}, 64'd1);
    check("wr_mbe", {60'd0, r_mbe}, 64'h3);
    check("wr_mwdata", {32'd0, r_mwdata}, 64'h00001234);
    check("wr_maddr", {48'd0, r_maddr}, 64'h0040);
    check("wr_hits", {32'd0, hits}, 64'd4);
    rd(16'h0043, 32'h0);
    check("merged_memreq", {63'd0, r_memreq}, 64'd0);
    check("merged_data", {32'd0, r_data}, 64'hDEAD1234);

    // Write miss does not allocate
    access(16'h0080, 1'b1, 4'hF, 32'h55667788, 1'b0, 32'h0, 1'b0);
    rd(16'h0080, 32'h55667788);
    check("noalloc_memreq", {63'd0, r_memreq}, 64'd1);
    check("noalloc_misses", {32'd0, misses}, 64'd8);

    // Bypass read of a cached line
    access(16'h0040, 1'b0, 4'hF, 32'h0, 1'b1, 32'h12345678, 1'b0);
    check("byp_memreq", {63'd0, r_memreq}, 64'd1);
    check("byp_data", {32'd0, r_data}, 64'h12345678);
    check("byp_hits", {32'd0, hits}, 64'd5);
    check("byp_misses", {32'd0, misses}, 64'd8);
    check("byp_trans", {32'd0, trans}, 64'(n_trans));
    rd(16'h0040, 32'h0);
    check("byp_untouched", {32'd0, r_data}, 64'hDEAD1234);
    check("byp_untouched_memreq", {63'd0, r_memreq}, 64'd0);

    // Flush raised while the memory response is outstanding
    access(16'h0400, 1'b0, 4'hF, 32'h0, 1'b0, 32'h44444444, 1'b1);
    check("fl_data", {32'd0, r_data}, 64'h44444444);
    @(negedge clk);
    req = 1'b1; addr = 16'h0040;
    #1;
    check("fl_pend_busy", {63'd0, busy}, 64'd1);
    check("fl_pend_nognt", {63'd0, gnt}, 64'd0);
    req = 1'b0;
    @(negedge clk);
    check("fl_state_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    check("fl_done_busy", {63'd0, busy}, 64'd0);
    rd(16'h0040, 32'hDEAD1234);
    check("fl_miss_memreq", {63'd0, r_memreq}, 64'd1);
    check("fl_misses", {32'd0, misses}, 64'd10);

    // Saturation: 14 more hits bring the total to 20
    for (int i = 0; i < 14; i++) rd(16'h0040, 32'h0);
    check("sat_main_hits", {32'd0, hits}, 64'd20);
    check("sat_hits", {60'd0, s_hits}, 64'd15);
    check("sat_misses", {60'd0, s_misses}, 64'd10);
    check("sat_trans", {60'd0, s_trans}, 64'd15);
    check("main_trans", {32'd0, trans}, 64'(n_trans));

    // Asynchronous reset while a memory request is pending
    @(negedge clk);
    req = 1'b1; addr = 16'h0800; we = 1'b0; be = 4'hF;
    @(posedge clk); #1 req = 1'b0;
    @(posedge clk); #1;
    check("ar_pending_req", {63'd0, mem_req}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_req_dropped", {63'd0, mem_req}, 64'd0);
    check("ar_misses", {32'd0, misses}, 64'd0);
    check("ar_busy", {63'd0, busy}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("ar_no_resp", {63'd0, rvalid}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
